// File: rtl/inst_scheduler_pkg.sv
// Shared opcode and scheduler-state definitions for the instruction scheduler.
package pkg_inst_sched;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 29;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_MOVE  = 3'd3,
        OP_FETCH = 3'd4,
        OP_EXEC  = 3'd5,
        OP_SYNC  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        CHECK   = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2,
        SETTLE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/inst_scheduler_fifo.sv
// Synchronous FIFO with first-word-fall-through head and registered count/full.
module inst_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_push  = i_push && !r_full;
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/inst_scheduler.sv
// Queues host instruction words and issues each one to the control unit
// only when its execution resource is free.
module inst_scheduler
    import pkg_inst_sched::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      h2f_io,
    input  logic             h2f_write,
    input  logic             sched_en,
    input  logic             err_clr,
    input  logic             ctrl_isrunning,
    input  logic             ldst_busy,
    input  logic             move_busy,
    input  logic             eu_busy,
    output logic [31:0]      issue_inst,
    output logic             issue_write,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_full,
    output logic             overflow,
    output logic             sched_idle
);

    sched_state_t r_state;
    logic [31:0]  r_issue_inst;
    logic         r_issue_write;
    logic         r_overflow;

    logic [31:0]  w_head;
    logic         w_empty;
    logic         w_full;
    op_t          w_op;
    logic         w_free;
    logic         w_issuable;
    logic         w_pop;

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (h2f_write),
        .i_pop   (w_pop),
        .i_wdata (h2f_io),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_op = op_t'(w_head[OPC_MSB:OPC_LSB]);

    // NOP/reserved are always free; SYNC only drains once everything is quiet
    always_comb begin
        w_free     = 1'b1;
        w_issuable = 1'b0;
        unique case (w_op)
            OP_LOAD, OP_STORE: begin
                w_free     = !ldst_busy;
                w_issuable = 1'b1;
            end
            OP_MOVE: begin
                w_free     = !move_busy;
                w_issuable = 1'b1;
            end
            OP_FETCH, OP_EXEC: begin
                w_free     = !eu_busy;
                w_issuable = 1'b1;
            end
            OP_SYNC: begin
                w_free = !ldst_busy && !move_busy && !eu_busy
                         && !ctrl_isrunning;
            end
            default: begin
                w_free = 1'b1;
            end
        endcase
    end

    assign w_pop = (r_state == CHECK) && !w_empty && sched_en && w_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= CHECK;
            r_issue_inst  <= '0;
            r_issue_write <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_issue_write <= 1'b0;
            if (h2f_write && w_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            unique case (r_state)
                CHECK: begin
                    if (w_pop && w_issuable) begin
                        r_issue_inst  <= w_head;
                        r_issue_write <= 1'b1;
                        r_state       <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (ctrl_isrunning) r_state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!ctrl_isrunning) r_state <= SETTLE;
                end
                SETTLE: begin
                    r_state <= CHECK;
                end
            endcase
        end
    end

    assign issue_inst  = r_issue_inst;
    assign issue_write = r_issue_write;
    assign fifo_full   = w_full;
    assign overflow    = r_overflow;
    assign sched_idle  = w_empty && (r_state == CHECK)
                         && !ldst_busy && !move_busy && !eu_busy;

endmodule
